// File: rtl/hsst_frame_pkg.sv
// Shared framing constants and FSM encoding for the HSST TX frame controller.
// K28.5 (0xBC) in byte0 marks idle; K27.7 (0xFB) and K29.7 (0xFD) delimit frames.
package hsst_frame_pkg;

  localparam logic [15:0] K_IDLE   = 16'h50BC;
  localparam logic [15:0] K_SOF    = 16'h50FB;
  localparam logic [15:0] K_EOF    = 16'h50FD;
  localparam logic [1:0]  K_IDLE_K = 2'b01;
  localparam logic [1:0]  K_SOF_K  = 2'b01;
  localparam logic [1:0]  K_EOF_K  = 2'b01;
  localparam logic [1:0]  DATA_K   = 2'b00;

  localparam int BURST_LEN_DEF = 960;
  // Payload counter sized so a 4096-word burst still fits.
  localparam int PAY_CNT_W     = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_HDR,
    S_PAY,
    S_EOF
  } state_t;

endpackage

// File: rtl/hsst_tx_frame_ctrl.sv
// Frames one buffered video line per burst: SOF, line header, BURST_LEN FIFO words, EOF.
// Latency: SOF one cycle after start; each FIFO read shows on tx_data 2 cycles later. No backpressure: a frame never stalls.
module hsst_tx_frame_ctrl
  import hsst_frame_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int LVL_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 link_ready,
  input  logic                 frame_start,
  input  logic [15:0]          fifo_rd_data,
  input  logic                 fifo_rd_empty,
  input  logic [LVL_WIDTH-1:0] fifo_rd_water_level,
  output logic                 fifo_rd_en,
  output logic [15:0]          tx_data,
  output logic [1:0]           tx_charisk,
  output logic                 busy,
  output logic                 underrun_err
);

  localparam logic [PAY_CNT_W-1:0] C_PAY_LAST = PAY_CNT_W'(BURST_LEN - 1);
  localparam logic [PAY_CNT_W-1:0] C_RD_STOP  = PAY_CNT_W'(BURST_LEN - 2);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PAY_CNT_W-1:0]   r_pay_cnt;
  logic [PAY_CNT_W-1:0]   w_pay_cnt_nxt;
  logic [15:0]            r_tx_data;
  logic [15:0]            w_tx_data_nxt;
  logic [1:0]             r_tx_k;
  logic [1:0]             w_tx_k_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic [15:0]            r_line_cnt;
  logic                   r_pend;
  logic                   r_underrun;
  logic                   w_start;
  logic                   w_pend;
  logic                   w_rd_en;

  assign w_start = link_ready && (32'(fifo_rd_water_level) >= 32'(BURST_LEN));
  assign w_pend  = r_pend | frame_start;

  // Reads lead the payload by two cycles, so the strobe spans SOF, HDR and all but the last two payload cycles.
  assign w_rd_en = (r_state == S_SOF) || (r_state == S_HDR) ||
                   ((r_state == S_PAY) && (r_pay_cnt < C_RD_STOP));

  always_comb begin
    w_state_nxt   = r_state;
    w_pay_cnt_nxt = r_pay_cnt;
    w_tx_data_nxt = K_IDLE;
    w_tx_k_nxt    = K_IDLE_K;
    w_busy_nxt    = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt   = S_SOF;
          w_tx_data_nxt = K_SOF;
          w_tx_k_nxt    = K_SOF_K;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      S_SOF: begin
        w_state_nxt   = S_HDR;
        w_tx_data_nxt = r_line_cnt;
        w_tx_k_nxt    = DATA_K;
      end
      S_HDR: begin
        w_state_nxt   = S_PAY;
        w_pay_cnt_nxt = '0;
        w_tx_data_nxt = fifo_rd_data;
        w_tx_k_nxt    = DATA_K;
      end
      S_PAY: begin
        if (r_pay_cnt == C_PAY_LAST) begin
          w_state_nxt   = S_EOF;
          w_tx_data_nxt = K_EOF;
          w_tx_k_nxt    = K_EOF_K;
        end else begin
          w_pay_cnt_nxt = r_pay_cnt + 1'b1;
          w_tx_data_nxt = fifo_rd_data;
          w_tx_k_nxt    = DATA_K;
        end
      end
      S_EOF: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pay_cnt <= '0;
      r_tx_data <= K_IDLE;
      r_tx_k    <= K_IDLE_K;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pay_cnt <= w_pay_cnt_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_k    <= w_tx_k_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // A vsync seen at any point up to and including the start cycle restarts numbering at the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_cnt <= '0;
      r_pend     <= 1'b0;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_pend <= 1'b0;
      if (w_pend) begin
        r_line_cnt <= '0;
      end
    end else begin
      r_pend <= w_pend;
      if (r_state == S_EOF) begin
        r_line_cnt <= r_line_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= r_underrun | (w_rd_en & fifo_rd_empty);
    end
  end

  assign fifo_rd_en   = w_rd_en;
  assign tx_data      = r_tx_data;
  assign tx_charisk   = r_tx_k;
  assign busy         = r_busy;
  assign underrun_err = r_underrun;

endmodule

// File: tb/tb_hsst_tx_frame_ctrl.sv
// Bench for hsst_tx_frame_ctrl with BURST_LEN = 4 and a counter-based FIFO whose word i is 16'h1000+i.
module tb_hsst_tx_frame_ctrl;
  import hsst_frame_pkg::*;

  localparam int BL = 4;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          link_ready = 1'b0;
  logic          frame_start = 1'b0;
  logic [15:0]   fifo_rd_data;
  logic          fifo_rd_empty;
  logic [LW-1:0] fifo_rd_water_level;
  logic          fifo_rd_en;
  logic [15:0]   tx_data;
  logic [1:0]    tx_charisk;
  logic          busy;
  logic          underrun_err;

  always #5 clk = ~clk;

  hsst_tx_frame_ctrl #(.BURST_LEN(BL), .LVL_WIDTH(LW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .link_ready          (link_ready),
    .frame_start         (frame_start),
    .fifo_rd_data        (fifo_rd_data),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_water_level (fifo_rd_water_level),
    .fifo_rd_en          (fifo_rd_en),
    .tx_data             (tx_data),
    .tx_charisk          (tx_charisk),
    .busy                (busy),
    .underrun_err        (underrun_err)
  );

  // FIFO model: words are implied by pointers; reading while empty returns filler and does not advance.
  int wr_ptr = 0;
  int rd_ptr = 0;
  bit lvl_force_en = 1'b0;
  int lvl_force = 0;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (rd_ptr < wr_ptr) begin
        fifo_rd_data <= 16'h1000 + 16'(rd_ptr);
        rd_ptr <= rd_ptr + 1;
      end else begin
        fifo_rd_data <= 16'hDEAD;
      end
    end
  end

  assign fifo_rd_empty       = (rd_ptr == wr_ptr);
  assign fifo_rd_water_level = lvl_force_en ? LW'(lvl_force) : LW'(wr_ptr - rd_ptr);

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [19:0] outs();
    return {tx_data, tx_charisk, fifo_rd_en, busy};
  endfunction

  typedef struct {
    logic        lr;
    int          lvl;
    logic        fs;
    logic [15:0] d;
    logic [1:0]  k;
    logic        rd;
    logic        bsy;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  k;
    logic        rd;
    logic        bsy;
  } exp_t;

  vec_t tbl[$];

  int hdr_q[$];
  int gap_q[$];
  int sof_cyc[$];
  int eof_cyc[$];
  int pay_q[$];
  int rd_cnt;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    link_ready = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Records the lane for ncyc cycles: headers, EOF-to-SOF idle gaps, payload words and read strobes.
  task automatic run_frames(input int ncyc, input int fs_at, input int lr_drop_at);
    bit prev_sof;
    bit seen_eof;
    int idle_run;
    hdr_q.delete(); gap_q.delete(); sof_cyc.delete(); eof_cyc.delete(); pay_q.delete();
    rd_cnt = 0; prev_sof = 1'b0; seen_eof = 1'b0; idle_run = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_cnt++;
      if (prev_sof) hdr_q.push_back(int'(tx_data));
      else if (tx_charisk == 2'b00) pay_q.push_back(int'(tx_data));
      prev_sof = 1'b0;
      if (tx_charisk == 2'b01 && tx_data == K_SOF) begin
        sof_cyc.push_back(i);
        if (seen_eof) gap_q.push_back(idle_run);
        prev_sof = 1'b1;
      end else if (tx_charisk == 2'b01 && tx_data == K_EOF) begin
        eof_cyc.push_back(i);
        seen_eof = 1'b1;
        idle_run = 0;
      end else if (tx_charisk == 2'b01 && tx_data == K_IDLE) begin
        idle_run++;
      end
      frame_start = (i == fs_at);
      if (i == lr_drop_at) link_ready = 1'b0;
    end
    frame_start = 1'b0;
  endtask

  initial begin
    int base;
    exp_t eq[$];
    exp_t e;
    bit was_idle;
    logic [15:0] line;
    bit pend;

    // ---------------- reset values ----------------
    #2 rst_n = 1'b0;
    #1;
    check("reset_async_outs", outs(), {K_IDLE, K_IDLE_K, 1'b0, 1'b0});
    check("reset_async_underrun", underrun_err, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_held_outs", outs(), {K_IDLE, K_IDLE_K, 1'b0, 1'b0});

    // ---------------- table: level 3 hold, then one frame ----------------
    lvl_force_en = 1'b1;
    lvl_force = 3;
    wr_ptr = 4;
    for (int i = 0; i < 20; i++) tbl.push_back('{1'b1, 3, 1'b0, K_IDLE, K_IDLE_K, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4, 1'b0, K_IDLE,  K_IDLE_K, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 0, 1'b0, K_SOF,   K_SOF_K,  1'b1, 1'b1});
    tbl.push_back('{1'b1, 0, 1'b0, 16'h0000, 2'b00,   1'b1, 1'b1});
    tbl.push_back('{1'b1, 0, 1'b0, 16'h1000, 2'b00,   1'b1, 1'b1});
    tbl.push_back('{1'b1, 0, 1'b0, 16'h1001, 2'b00,   1'b1, 1'b1});
    tbl.push_back('{1'b1, 0, 1'b0, 16'h1002, 2'b00,   1'b0, 1'b1});
    tbl.push_back('{1'b1, 0, 1'b0, 16'h1003, 2'b00,   1'b0, 1'b1});
    tbl.push_back('{1'b1, 0, 1'b0, K_EOF,   K_EOF_K,  1'b0, 1'b1});
    tbl.push_back('{1'b1, 0, 1'b0, K_IDLE,  K_IDLE_K, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 0, 1'b0, K_IDLE,  K_IDLE_K, 1'b0, 1'b0});

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), {tbl[i].d, tbl[i].k, tbl[i].rd, tbl[i].bsy});
      link_ready = tbl[i].lr;
      lvl_force = tbl[i].lvl;
      frame_start = tbl[i].fs;
    end
    lvl_force_en = 1'b0;

    // ---------------- three back-to-back frames ----------------
    do_reset();
    base = rd_ptr;
    wr_ptr = wr_ptr + 12;
    link_ready = 1'b1;
    run_frames(30, -1, -1);
    check("b2b_nframes", hdr_q.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("b2b_hdr%0d", k), (k < hdr_q.size()) ? hdr_q[k] : -1, k);
    check("b2b_ngaps", gap_q.size(), 2);
    for (int k = 0; k < 2; k++)
      check($sformatf("b2b_gap%0d", k), (k < gap_q.size()) ? gap_q[k] : -1, 1);
    check("b2b_rd_cycles", rd_cnt, 12);
    check("b2b_npay", pay_q.size(), 12);
    for (int k = 0; k < 12; k++)
      check($sformatf("b2b_pay%0d", k), (k < pay_q.size()) ? pay_q[k] : -1,
            int'(16'(4096 + base + k)));

    // ---------------- frame_start during the payload of header 5 ----------------
    do_reset();
    wr_ptr = wr_ptr + 28;
    link_ready = 1'b1;
    run_frames(60, 43, -1);
    check("fs_nframes", hdr_q.size(), 7);
    for (int k = 0; k < 7; k++)
      check($sformatf("fs_hdr%0d", k), (k < hdr_q.size()) ? hdr_q[k] : -1, (k == 6) ? 0 : k);

    // ---------------- underrun: only 2 words behind a level of 4 ----------------
    do_reset();
    lvl_force_en = 1'b1;
    lvl_force = 4;
    wr_ptr = rd_ptr + 2;
    link_ready = 1'b1;
    run_frames(12, -1, 1);
    check("urun_flag", underrun_err, 1'b1);
    check("urun_nsof", sof_cyc.size(), 1);
    check("urun_eof_cyc", (eof_cyc.size() > 0) ? eof_cyc[0] : -1, 6);
    check("urun_npay", pay_q.size(), 4);
    check("urun_rd_cycles", rd_cnt, 4);
    repeat (10) @(negedge clk);
    check("urun_sticky", underrun_err, 1'b1);
    rst_n = 1'b0;
    #1;
    check("urun_cleared", underrun_err, 1'b0);
    lvl_force_en = 1'b0;

    // ---------------- link_ready dropped in HDR ----------------
    do_reset();
    wr_ptr = rd_ptr + 8;
    link_ready = 1'b1;
    run_frames(25, -1, 1);
    check("lrdrop_nsof", sof_cyc.size(), 1);
    check("lrdrop_sof_cyc", (sof_cyc.size() > 0) ? sof_cyc[0] : -1, 0);
    check("lrdrop_eof_cyc", (eof_cyc.size() > 0) ? eof_cyc[0] : -1, 6);
    check("lrdrop_rd_cycles", rd_cnt, 4);

    // ---------------- async reset in the middle of a payload ----------------
    link_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_before", {tx_charisk, fifo_rd_en, busy}, {2'b00, 1'b1, 1'b1});
    rst_n = 1'b0;
    #1;
    check("midrst_outs", outs(), {K_IDLE, K_IDLE_K, 1'b0, 1'b0});

    // ---------------- randomized traffic against the frame-level model ----------------
    do_reset();
    line = 16'd0;
    pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      was_idle = (eq.size() == 0);
      if (was_idle) e = '{K_IDLE, K_IDLE_K, 1'b0, 1'b0};
      else e = eq.pop_front();
      check($sformatf("rand%0d", c), {outs(), underrun_err}, {e.d, e.k, e.rd, e.bsy, 1'b0});
      link_ready = ($urandom_range(0, 9) != 0);
      frame_start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) < 45) wr_ptr = wr_ptr + 1;
      if (frame_start) pend = 1'b1;
      if (was_idle && link_ready && ((wr_ptr - rd_ptr) >= BL)) begin
        if (pend) begin
          line = 16'd0;
          pend = 1'b0;
        end
        eq.push_back('{K_SOF, K_SOF_K, 1'b1, 1'b1});
        eq.push_back('{line, 2'b00, (1 < BL), 1'b1});
        for (int j = 0; j < BL; j++)
          eq.push_back('{16'h1000 + 16'(rd_ptr + j), 2'b00, (j + 2 < BL), 1'b1});
        eq.push_back('{K_EOF, K_EOF_K, 1'b0, 1'b1});
        line = line + 16'd1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
